id_imm_ctrl: RTL
================

ID_IMM_CTRL -- requirements
Module: ID_IMM_CTRL

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the issued-instruction counter.
REQ-002 SHALL have port clock_in, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_in, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port flush_in, input, 1: discards all held instructions.
REQ-005 SHALL have port if_valid_in, input, 1: fetch stage offers an instruction.
REQ-006 SHALL have port if_ins_in, input, 32: offered instruction word.
REQ-007 SHALL have port if_ready_out, output, 1: block can accept an instruction.
REQ-008 SHALL have port ex_ready_in, input, 1: downstream accepts the head entry.
REQ-009 SHALL have port ex_valid_out, output, 1: head entry valid.
REQ-010 SHALL have port ins_out, output, 32: head instruction word, which drives the immediate generator's instruction input.
REQ-011 SHALL have port imm_gen_unit_type_out, output, 3: immediate-type select for the immediate generator.
REQ-012 SHALL have port illegal_out, output, 1: head opcode is unrecognised.
REQ-013 SHALL have port issue_count_out, output, CNT_WIDTH: count of instructions issued to execute.

Function
REQ-014 SHALL be a 2-entry in-order buffer with states EMPTY (0 entries), ONE (1 entry) and TWO (2 entries).
REQ-015 SHALL treat an accept as if_valid_in & if_ready_out and an issue as ex_valid_out & ex_ready_in, both in the same cycle.
REQ-016 SHALL drive if_ready_out = (state != TWO), derived from registered state only, with no combinational path from ex_ready_in.
REQ-017 SHALL drive ex_valid_out = (state != EMPTY); head outputs are registered and SHALL be held stable while ex_valid_out=1 and ex_ready_in=0.
REQ-018 SHALL follow these transitions: EMPTY+accept->ONE; ONE+accept only->TWO; ONE+issue only->EMPTY; ONE+accept+issue->ONE with the new word at the head next cycle; TWO+issue->ONE with the second entry promoted to head; otherwise hold.
REQ-019 SHALL have 1-cycle latency: a word accepted into EMPTY appears on ins_out the next cycle.
REQ-020 SHALL decode if_ins_in[6:0] at accept time and store the type with the word: 0010011, 0000011, 1100111, 0001111, 1110011 -> 3'b000 (I); 0100011 -> 3'b001 (S); 1100011 -> 3'b010 (B); 0110111, 0010111 -> 3'b011 (U); 1101111 -> 3'b100 (J); 0110011 -> 3'b111 (none).
REQ-021 SHALL, for any other opcode, store type 3'b111 and illegal=1; illegal words are still buffered and issued normally.
REQ-022 SHALL increment issue_count_out by 1 per issue, wrapping modulo 2^CNT_WIDTH without saturating.
REQ-023 SHALL, on flush_in=1, go to EMPTY next cycle; flush takes priority over everything, and any same-cycle accept is discarded.
REQ-024 SHALL still count a same-cycle issue during flush_in=1.
REQ-025 SHALL drive imm_gen_unit_type_out=3'b111, illegal_out=0 and ins_out=32'h00000013 (NOP) when EMPTY.

Reset
REQ-026 SHALL, while reset_in=1 at a clock edge, go to EMPTY and clear issue_count_out to 0, with outputs per REQ-025.
REQ-027 SHALL give reset priority over flush, accept and issue, including mid-operation in state TWO.
REQ-028 SHALL hold if_ready_out=1 and ex_valid_out=0 in the first cycle after reset is released.

Verification
REQ-029 SHALL cover single issue: accept 32'h00500093 with ex_ready_in=1 -> next cycle ex_valid_out=1, type 000, illegal 0, and count 1 after the issue.
REQ-030 SHALL cover backpressure: ex_ready_in=0, accept 0x00112023 (S) then 0x00208463 (B) -> state TWO, if_ready_out=0, head stable at 0x00112023; ex_ready_in=1 -> issue S, then B, in order.
REQ-031 SHALL cover streaming: continuous valid/ready for 10 cycles -> one issue per cycle and count 10.
REQ-032 SHALL cover decode: LUI 0x000012B7 -> type 011, JAL 0x0000006F -> 100, ADD 0x002081B3 -> 111 with illegal 0, opcode 7'b1111111 -> type 111 with illegal 1.
REQ-033 SHALL cover flush in TWO with a concurrent accept -> next cycle EMPTY, ex_valid_out=0, nothing from before the flush issued.
REQ-034 SHALL cover wrap and reset: CNT_WIDTH=4, 17 issues -> count 1; assert reset_in in TWO -> EMPTY and count 0.

Source files
------------

// File: rtl/id_imm_ctrl.sv
// Decode-stage holding buffer with immediate-type pre-decode.
// Holds up to two fetched instructions in order. The immediate type is
// decoded once, when a word is accepted, and then travels with the word.
// An issued-instruction counter tracks every handshake toward execute.

module id_imm_ctrl #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clock_in,
   input  logic                 reset_in,
   input  logic                 flush_in,
   input  logic                 if_valid_in,
   input  logic [31:0]          if_ins_in,
   output logic                 if_ready_out,
   input  logic                 ex_ready_in,
   output logic                 ex_valid_out,
   output logic [31:0]          ins_out,
   output logic [2:0]           imm_gen_unit_type_out,
   output logic                 illegal_out,
   output logic [CNT_WIDTH-1:0] issue_count_out
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [31:0] NOP_INS = 32'h0000_0013;
   localparam logic [2:0]  TYPE_I    = 3'b000;
   localparam logic [2:0]  TYPE_S    = 3'b001;
   localparam logic [2:0]  TYPE_B    = 3'b010;
   localparam logic [2:0]  TYPE_U    = 3'b011;
   localparam logic [2:0]  TYPE_J    = 3'b100;
   localparam logic [2:0]  TYPE_NONE = 3'b111;

   state_t               state_q, state_d;
   logic [31:0]          headIns_q, headIns_d;
   logic [2:0]           headType_q, headType_d;
   logic                 headIll_q, headIll_d;
   logic [31:0]          tailIns_q, tailIns_d;
   logic [2:0]           tailType_q, tailType_d;
   logic                 tailIll_q, tailIll_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   logic       accept;
   logic       issue;
   logic [2:0] newType;
   logic       newIll;

   // Opcode to immediate-type lookup; unknown opcodes are flagged illegal
   // but otherwise flow through the buffer like any other word.
   always_comb begin
      newType = TYPE_NONE;
      newIll  = 1'b0;
      unique case (if_ins_in[6:0])
         7'b0010011, 7'b0000011, 7'b1100111,
         7'b0001111, 7'b1110011: newType = TYPE_I;
         7'b0100011:             newType = TYPE_S;
         7'b1100011:             newType = TYPE_B;
         7'b0110111, 7'b0010111: newType = TYPE_U;
         7'b1101111:             newType = TYPE_J;
         7'b0110011:             newType = TYPE_NONE;
         default: begin
            newType = TYPE_NONE;
            newIll  = 1'b1;
         end
      endcase
   end

   // Handshakes depend only on registered state, so ex_ready_in never
   // reaches if_ready_out combinationally. Empty buffer shows a NOP.
   assign if_ready_out          = (state_q != TWO);
   assign ex_valid_out          = (state_q != EMPTY);
   assign ins_out               = ex_valid_out ? headIns_q  : NOP_INS;
   assign imm_gen_unit_type_out = ex_valid_out ? headType_q : TYPE_NONE;
   assign illegal_out           = ex_valid_out & headIll_q;
   assign issue_count_out       = count_q;
   assign accept                = if_valid_in & if_ready_out;
   assign issue                 = ex_valid_out & ex_ready_in;

   // Next-state logic: flush empties the buffer and drops any accept, but a
   // same-cycle issue has already happened downstream and is still counted.
   always_comb begin
      state_d    = state_q;
      headIns_d  = headIns_q;
      headType_d = headType_q;
      headIll_d  = headIll_q;
      tailIns_d  = tailIns_q;
      tailType_d = tailType_q;
      tailIll_d  = tailIll_q;
      count_d    = count_q + CNT_WIDTH'(issue);
      if (flush_in) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d    = ONE;
                  headIns_d  = if_ins_in;
                  headType_d = newType;
                  headIll_d  = newIll;
               end
            end
            ONE: begin
               if (accept && issue) begin
                  headIns_d  = if_ins_in;
                  headType_d = newType;
                  headIll_d  = newIll;
               end else if (accept) begin
                  state_d    = TWO;
                  tailIns_d  = if_ins_in;
                  tailType_d = newType;
                  tailIll_d  = newIll;
               end else if (issue) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (issue) begin
                  state_d    = ONE;
                  headIns_d  = tailIns_q;
                  headType_d = tailType_q;
                  headIll_d  = tailIll_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // State register with synchronous reset taking priority over everything.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q    <= EMPTY;
         headIns_q  <= NOP_INS;
         headType_q <= TYPE_NONE;
         headIll_q  <= 1'b0;
         tailIns_q  <= NOP_INS;
         tailType_q <= TYPE_NONE;
         tailIll_q  <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         headIns_q  <= headIns_d;
         headType_q <= headType_d;
         headIll_q  <= headIll_d;
         tailIns_q  <= tailIns_d;
         tailType_q <= tailType_d;
         tailIll_q  <= tailIll_d;
         count_q    <= count_d;
      end
   end

endmodule
